ysyx_24080006_lsu_master: RTL

- Single-outstanding AXI4 master for the core's load/store unit.
- Converts one core memory request (load or store, byte/half/word) into one single-beat AXI transaction. Loads use AR/R; stores use AW/W/B.
- Performs store lane steering and strobe generation, and load extraction with sign/zero extension.
- Drives the same AXI channel set the peripheral slaves (CLINT, UART, SRAM bridge) respond on, through the crossbar.

---
 rtl/ysyx_24080006_lsu_master.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24080006_lsu_master.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_lsu_master
//
// Single-outstanding AXI4 master for the core load/store unit. One core
// request (load or store, byte/half/word) becomes one single-beat AXI
// transaction: loads use AR/R, stores use AW/W/B. Stores are lane-steered
// with a matching write strobe. Load data is extracted from the addressed
// lane and sign- or zero-extended.
//
// Optional build macro:
//   YSYX_24080006_LSU_MISALIGN_TRAP_EN
//     defined   : a misaligned half/word request produces no bus traffic and
//                 completes one cycle later with rsp_err = 1, rsp_rdata = 0.
//     undefined : misaligned requests are issued unchanged. Lanes shifted
//                 past bit 31 are dropped.
//
// Ports:
//   clock, reset              clock, synchronous active-high reset
//   req_valid/req_ready       core request handshake (ready = idle)
//   req_we                    1 = store, 0 = load
//   req_addr, req_wdata       byte address, right-aligned store data
//   req_funct3                RV funct3 (b/h/w/bu/hu; others act as word)
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata, rsp_err        extended load data (0 for stores), bus error
//   aw*/w*/b*                 AXI write address/data/response channels
//   ar*/r*                    AXI read address/data channels
// ---------------------------------------------------------------------------
module ysyx_24080006_lsu_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [2:0]        awsize,

  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,

  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,

  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,

  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // Single-beat only; rlast carries no information for this master.
  logic unused_rlast;
  assign unused_rlast = rlast;

  // Encodings 011 and 11x fall through to a word access.
  logic [2:0] req_size;
  assign req_size = req_funct3[1] ? 3'd2 : {1'b0, req_funct3[1:0]};

  logic [DATA_W-1:0] req_wdata_steered;
  logic [3:0]        req_wstrb;
  always_comb begin
    req_wdata_steered = req_wdata << {req_addr[1:0], 3'b000};
    case (req_size)
      3'd0:    req_wstrb = 4'b0001 << req_addr[1:0];
      3'd1:    req_wstrb = 4'b0011 << req_addr[1:0];
      default: req_wstrb = 4'b1111;
    endcase
  end

`ifdef YSYX_24080006_LSU_MISALIGN_TRAP_EN
  logic req_misaligned;
  assign req_misaligned = ((req_size == 3'd1) && req_addr[0]) ||
                          ((req_size == 3'd2) && (req_addr[1:0] != 2'b00));
`endif

  // Load extraction from the addressed lane.
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_data;
  always_comb begin
    ld_shift = rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  logic aw_hs, w_hs;
  assign aw_hs = awvalid_q && awready;
  assign w_hs  = wvalid_q && wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          size_d   = req_size;
          wdata_d  = req_wdata_steered;
          wstrb_d  = req_wstrb;
`ifdef YSYX_24080006_LSU_MISALIGN_TRAP_EN
          if (req_misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else
`endif
          if (req_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end

      RD_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end

      RD_R: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (rresp != 2'b00);
          rsp_rdata_d = ld_data;
          state_d     = IDLE;
        end
      end

      WR_AW_W: begin
        // AW and W retire independently; both may complete in one cycle.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end

      WR_B: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (bresp != 2'b00);
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Held off during the response cycle so a new request starts after it.
  assign req_ready = (state_q == IDLE) && !rsp_valid_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign awaddr  = addr_q;
  assign awsize  = size_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  assign araddr  = addr_q;
  assign arsize  = size_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule
